// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module   : lsu
//  Purpose  : Load/store unit placed after the execute ALU. Accepts one access
//             at a time, runs a single request/grant/response bus transaction
//             and returns extended load data (or a store acknowledgement) to
//             writeback over a valid/ready handshake.
//  Ports    : clk, rst_n (synchronous, active-low)
//             in_valid/in_ready, alu_result, data_rs2, mem_wen, mem_funct3
//             out_valid/out_ready, rdata, err
//             bus_req/bus_gnt, bus_we, bus_addr, bus_wdata, bus_wstrb,
//             bus_rvalid, bus_rdata, bus_rerr
//  Params   : TIMEOUT - bus cycles allowed in REQ+WAIT (1..65535)
//  Macros   : LSU_MISALIGN_CHECK_EN - fault misaligned halfword/word accesses
//             without touching the bus
//  Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] data_rs2,
  input  logic        mem_wen,
  input  logic [2:0]  mem_funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rerr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept, w_illegal, w_misalign, w_fault, w_tmo;
  logic [31:0] w_wdata, w_load;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign in_ready  = (r_state == S_IDLE) && rst_n;
  assign out_valid = (r_state == S_RESP);
  assign bus_req   = (r_state == S_REQ);
  assign bus_we    = r_we;
  assign bus_addr  = {r_addr[31:2], 2'b00};
  assign bus_wdata = r_wdata;
  assign bus_wstrb = r_wstrb;
  assign rdata     = r_rdata;
  assign err       = r_err;

  assign w_accept = in_valid && in_ready;
  // Counter is never cleared on the REQ->WAIT move, so >= covers a grant
  // landing on the last allowed cycle.
  assign w_tmo    = (r_cnt >= c_tmo_last);

  // Stores only define byte/half/word; loads additionally allow 100/101.
  always_comb begin
    w_illegal = 1'b0;
    if (mem_wen) w_illegal = mem_funct3[2] || (mem_funct3[1:0] == 2'b11);
    else         w_illegal = (mem_funct3 == 3'b011) || (mem_funct3 == 3'b110) ||
                             (mem_funct3 == 3'b111);
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    case (mem_funct3[1:0])
      2'b01:   w_misalign = alu_result[0];
      2'b10:   w_misalign = |alu_result[1:0];
      default: w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault = w_illegal || w_misalign;

  // Store lanes: data is replicated so the strobe alone selects the lanes.
  always_comb begin
    w_wdata = 32'h0;
    w_wstrb = 4'h0;
    if (mem_wen) begin
      case (mem_funct3[1:0])
        2'b00: begin
          w_wdata = {4{data_rs2[7:0]}};
          w_wstrb = 4'b0001 << alu_result[1:0];
        end
        2'b01: begin
          w_wdata = {2{data_rs2[15:0]}};
          w_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_wdata = data_rs2;
          w_wstrb = 4'hF;
        end
      endcase
    end
  end

  // Load extraction from the returned word using the registered address.
  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = bus_rdata[7:0];
      2'b01:   w_byte = bus_rdata[15:8];
      2'b10:   w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = bus_rdata;
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = 32'h0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_fault ? S_RESP : S_REQ;
      S_REQ:  if (bus_gnt) w_state_nxt = S_WAIT;
              else if (w_tmo) w_state_nxt = S_RESP;
      S_WAIT: if (bus_rvalid || w_tmo) w_state_nxt = S_RESP;
      S_RESP: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= 32'h0;
      r_we     <= 1'b0;
      r_funct3 <= 3'h0;
      r_wdata  <= 32'h0;
      r_wstrb  <= 4'h0;
      r_cnt    <= 16'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= alu_result;
            r_we     <= mem_wen;
            r_funct3 <= mem_funct3;
            r_wdata  <= w_wdata;
            r_wstrb  <= w_wstrb;
            r_cnt    <= 16'h0;
            r_rdata  <= 32'h0;
            r_err    <= w_fault;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 16'd1;
          if (!bus_gnt && w_tmo) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (bus_rvalid) begin
            r_rdata <= (r_we || bus_rerr) ? 32'h0 : w_load;
            r_err   <= bus_rerr;
          end else if (w_tmo) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Directed self-checking bench for lsu. A second instance with
//             TIMEOUT=4 shares all inputs and is observed only for the
//             timeout scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, mem_wen, out_ready, bus_gnt, bus_rvalid, bus_rerr;
  logic [31:0] alu_result, data_rs2, bus_rdata;
  logic [2:0]  mem_funct3;

  logic        in_ready, out_valid, err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  logic        t_in_ready, t_out_valid, t_err, t_bus_req, t_bus_we;
  logic [31:0] t_rdata, t_bus_addr, t_bus_wdata;
  logic [3:0]  t_bus_wstrb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .data_rs2(data_rs2), .mem_wen(mem_wen),
    .mem_funct3(mem_funct3), .out_valid(out_valid), .out_ready(out_ready),
    .rdata(rdata), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_rerr(bus_rerr)
  );

  lsu #(.TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
    .alu_result(alu_result), .data_rs2(data_rs2), .mem_wen(mem_wen),
    .mem_funct3(mem_funct3), .out_valid(t_out_valid), .out_ready(out_ready),
    .rdata(t_rdata), .err(t_err), .bus_req(t_bus_req), .bus_we(t_bus_we),
    .bus_addr(t_bus_addr), .bus_wdata(t_bus_wdata), .bus_wstrb(t_bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .bus_rerr(bus_rerr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    in_valid = 0; mem_wen = 0; mem_funct3 = 0; alu_result = 0; data_rs2 = 0;
    out_ready = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_rerr = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".err"},       32'(err), 0);
    chk({tag, ".rdata"},     rdata, 0);
    chk({tag, ".bus_req"},   32'(bus_req), 0);
    chk({tag, ".bus_we"},    32'(bus_we), 0);
    chk({tag, ".bus_addr"},  bus_addr, 0);
    chk({tag, ".bus_wdata"}, bus_wdata, 0);
    chk({tag, ".bus_wstrb"}, 32'(bus_wstrb), 0);
  endtask

  // Access with immediate grant and response: handshake T, out_valid at T+3.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input logic re,
                      input logic [31:0] e_addr, input logic [31:0] e_wdata,
                      input logic [3:0] e_wstrb, input logic [31:0] e_rdata,
                      input logic e_err);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    in_valid = 1; mem_wen = we; mem_funct3 = f3; alu_result = a; data_rs2 = d;
    tick();
    in_valid = 0; bus_gnt = 1;
    chk({tag, ".req"},   32'(bus_req), 1);
    chk({tag, ".addr"},  bus_addr, e_addr);
    chk({tag, ".we"},    32'(bus_we), 32'(we));
    chk({tag, ".wstrb"}, 32'(bus_wstrb), 32'(e_wstrb));
    if (we) chk({tag, ".wdata"}, bus_wdata, e_wdata);
    tick();
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = rd; bus_rerr = re;
    chk({tag, ".req_drop"}, 32'(bus_req), 0);
    chk({tag, ".ov_early"}, 32'(out_valid), 0);
    tick();
    bus_rvalid = 0; bus_rerr = 0; bus_rdata = 0;
    chk({tag, ".out_valid"}, 32'(out_valid), 1);
    chk({tag, ".rdata"},     rdata, e_rdata);
    chk({tag, ".err"},       32'(err), 32'(e_err));
    chk({tag, ".busy"},      32'(in_ready), 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({tag, ".ov_clr"}, 32'(out_valid), 0);
  endtask

  // Faulting access: out_valid at T+1, no bus request ever raised.
  task automatic fault_xact(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a);
    in_valid = 1; mem_wen = we; mem_funct3 = f3; alu_result = a; data_rs2 = 32'h5A5A5A5A;
    tick();
    in_valid = 0;
    chk({tag, ".out_valid"}, 32'(out_valid), 1);
    chk({tag, ".err"},       32'(err), 1);
    chk({tag, ".rdata"},     rdata, 0);
    chk({tag, ".no_req"},    32'(bus_req), 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({tag, ".no_req2"},  32'(bus_req), 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    quiet_inputs();
    rst_n = 0;
    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 0);
    chk_all_zero("rst");
    rst_n = 1;
    #1;
    chk("rst.in_ready_after", 32'(in_ready), 1);

    // Loads
    xact("lb",  0, 3'b000, 32'h80000003, 0, 32'h85FF1234, 0, 32'h80000000, 0, 4'h0, 32'hFFFFFF85, 0);
    xact("lhu", 0, 3'b101, 32'h80000002, 0, 32'hBEEF0000, 0, 32'h80000000, 0, 4'h0, 32'h0000BEEF, 0);
    xact("lw_rerr", 0, 3'b010, 32'h80000010, 0, 32'h12345678, 1, 32'h80000010, 0, 4'h0, 32'h0, 1);
    xact("lh",  0, 3'b001, 32'h80000000, 0, 32'h00008001, 0, 32'h80000000, 0, 4'h0, 32'hFFFF8001, 0);
    xact("lbu", 0, 3'b100, 32'h80000001, 0, 32'h00009A00, 0, 32'h80000000, 0, 4'h0, 32'h0000009A, 0);
    xact("lh_hi", 0, 3'b001, 32'h80000012, 0, 32'h7FFE0000, 0, 32'h80000010, 0, 4'h0, 32'h00007FFE, 0);

    // Stores
    xact("sb", 1, 3'b000, 32'h80000001, 32'h000000A5, 32'hFFFFFFFF, 0, 32'h80000000, 32'hA5A5A5A5, 4'b0010, 32'h0, 0);
    xact("sw", 1, 3'b010, 32'h80000008, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 32'h80000008, 32'hDEADBEEF, 4'hF, 32'h0, 0);

    // Misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
    fault_xact("lw_mis", 0, 3'b010, 32'h80000002);
`else
    xact("lw_mis", 0, 3'b010, 32'h80000002, 0, 32'h11223344, 0, 32'h80000000, 0, 4'h0, 32'h11223344, 0);
`endif

    // Illegal funct3
    fault_xact("ill_ld", 0, 3'b011, 32'h80000000);
    fault_xact("ill_st", 1, 3'b100, 32'h80000004);

    // SH with the grant withheld for 5 cycles
    in_valid = 1; mem_wen = 1; mem_funct3 = 3'b001; alu_result = 32'h80000006; data_rs2 = 32'h1234ABCD;
    tick();
    in_valid = 0; data_rs2 = 0; alu_result = 0;
    for (int i = 0; i < 5; i++) begin
      chk("sh.req",   32'(bus_req), 1);
      chk("sh.addr",  bus_addr, 32'h80000004);
      chk("sh.wdata", bus_wdata, 32'hABCDABCD);
      chk("sh.wstrb", 32'(bus_wstrb), 32'hC);
      chk("sh.we",    32'(bus_we), 1);
      tick();
    end
    bus_gnt = 1;
    tick();
    bus_gnt = 0; bus_rvalid = 1;
    tick();
    bus_rvalid = 0;
    chk("sh.out_valid", 32'(out_valid), 1);
    chk("sh.err",       32'(err), 0);
    out_ready = 1;
    tick();
    out_ready = 0;

    // LW with writeback stalled for 10 cycles
    in_valid = 1; mem_wen = 0; mem_funct3 = 3'b010; alu_result = 32'h80000020;
    tick();
    in_valid = 0; bus_gnt = 1;
    tick();
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
    tick();
    bus_rvalid = 0; bus_rdata = 0;
    for (int i = 0; i < 10; i++) begin
      chk("stall.out_valid", 32'(out_valid), 1);
      chk("stall.rdata",     rdata, 32'hCAFEF00D);
      chk("stall.in_ready",  32'(in_ready), 0);
      tick();
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("stall.release", 32'(in_ready), 1);

    // Reset asserted while waiting for the response
    in_valid = 1; mem_wen = 0; mem_funct3 = 3'b010; alu_result = 32'h80000030;
    tick();
    in_valid = 0; bus_gnt = 1;
    tick();
    bus_gnt = 0;
    chk("rstw.addr_before", bus_addr, 32'h80000030);
    rst_n = 0;
    tick();
    chk("rstw.in_ready", 32'(in_ready), 0);
    chk_all_zero("rstw");
    rst_n = 1; bus_rvalid = 1; bus_rdata = 32'h87654321;
    tick();
    bus_rvalid = 0; bus_rdata = 0;
    chk("rstw.late_ov", 32'(out_valid), 0);
    chk("rstw.idle",    32'(in_ready), 1);

    // Timeout on the TIMEOUT=4 instance: grant now, response never
    do_reset();
    in_valid = 1; mem_wen = 0; mem_funct3 = 3'b010; alu_result = 32'h80000040;
    tick();
    in_valid = 0; bus_gnt = 1;
    chk("tmo.req", 32'(t_bus_req), 1);
    tick();
    bus_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      chk("tmo.ov_early", 32'(t_out_valid), 0);
      tick();
    end
    chk("tmo.out_valid", 32'(t_out_valid), 1);
    chk("tmo.err",       32'(t_err), 1);
    chk("tmo.rdata",     t_rdata, 0);
    bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;
    tick();
    bus_rvalid = 0; bus_rdata = 0;
    chk("tmo.late_err",   32'(t_err), 1);
    chk("tmo.late_rdata", t_rdata, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("tmo.ov_clr",   32'(t_out_valid), 0);
    chk("tmo.in_ready", 32'(t_in_ready), 1);
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
